// File: rtl/shift_issue_pipe.sv
// ---------------------------------------------------------------------------
// shift_issue_pipe
//   Two-stage valid/ready shift unit for the ALU shift path.
//   Stage 1 registers the request (operand, shift amount, op, tag). A single
//   logical-right barrel shifter is driven straight from those registers.
//   Left shifts are built by bit-reversal around that shifter, and arithmetic
//   shifts OR in a sign-fill mask. Stage 2 registers the result and holds it
//   under backpressure. Completed transfers are counted.
//
//   Build option: define SHIFT_ROTATE_EN to turn op 2'b11 into rotate-right.
//   Without it, op 2'b11 completes with out_y = 0 and out_err = 1.
//
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : request present
//   in_ready    : unit can take a request this cycle (independent of in_valid)
//   in_a        : operand
//   in_shamt    : shift amount 0..31
//   in_op       : 00 SLL, 01 SRL, 10 SRA, 11 reserved / ROR
//   in_tag      : opaque tag, returned with the result
//   out_valid   : result present
//   out_ready   : consumer takes the result this cycle
//   out_y       : shift result (held while stalled, keeps last value when idle)
//   out_tag     : tag of the result
//   out_err     : result came from an unsupported op
//   busy        : either stage holds an op
//   op_count    : completed transfers, wraps
// ---------------------------------------------------------------------------
module shift_issue_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [4:0]       in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // The shifter datapath is hard-wired for 32 bits.
  if (WIDTH != 32) begin : g_width_chk
    $error("shift_issue_pipe: only WIDTH = 32 is supported");
  end

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // -------------------------------------------------------------------------
  // Shifter helpers
  // -------------------------------------------------------------------------
  function automatic logic [31:0] f_rev(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Five-level logical-right barrel shifter.
  function automatic logic [31:0] f_core(input logic [31:0] v, input logic [4:0] s);
    logic [31:0] t;
    t = v;
    if (s[0]) t = {1'b0,  t[31:1]};
    if (s[1]) t = {2'b0,  t[31:2]};
    if (s[2]) t = {4'b0,  t[31:4]};
    if (s[3]) t = {8'b0,  t[31:8]};
    if (s[4]) t = {16'b0, t[31:16]};
    return t;
  endfunction

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [31:0]      r_a;
  logic [4:0]       r_shamt;
  logic [1:0]       r_op;
  logic [TAG_W-1:0] r_tag;

  logic             r_s2_valid;
  logic [31:0]      r_y;
  logic [TAG_W-1:0] r_otag;
  logic             r_err;

  logic [CNT_W-1:0] r_count;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic w_s2_free;
  logic w_accept;
  logic w_s1_adv;
  logic w_xfer;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_xfer    = r_s2_valid && out_ready;

  // -------------------------------------------------------------------------
  // Datapath (from stage-1 registers)
  // -------------------------------------------------------------------------
  logic [31:0] w_srl;
  logic [31:0] w_sll;
  logic [31:0] w_sign_mask;
  logic [31:0] w_sra;
  logic [31:0] w_y;
  logic        w_err;

  assign w_srl       = f_core(r_a, r_shamt);
  assign w_sll       = f_rev(f_core(f_rev(r_a), r_shamt));
  // Mask of the vacated top bits: ~(all-ones >> s).
  assign w_sign_mask = ~f_core('1, r_shamt);
  assign w_sra       = w_srl | (r_a[31] ? w_sign_mask : '0);

`ifdef SHIFT_ROTATE_EN
  logic [31:0] w_ror_hi;
  // a << (32 - s) as a reversed right shift; 32 - s fits in 5 bits for s > 0
  // and the s = 0 term is zero, leaving a unchanged.
  assign w_ror_hi = (r_shamt == 5'd0) ? '0
                                      : f_rev(f_core(f_rev(r_a), 5'd0 - r_shamt));
`endif

  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (r_op)
      OP_SLL: w_y = w_sll;
      OP_SRL: w_y = w_srl;
      OP_SRA: w_y = w_sra;
      OP_RSV: begin
`ifdef SHIFT_ROTATE_EN
        w_y   = w_srl | w_ror_hi;
        w_err = 1'b0;
`else
        w_y   = '0;
        w_err = 1'b1;
`endif
      end
      default: begin
        w_y   = '0;
        w_err = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 1
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_shamt    <= '0;
      r_op       <= '0;
      r_tag      <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_a        <= in_a;
      r_shamt    <= in_shamt;
      r_op       <= in_op;
      r_tag      <= in_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_otag     <= '0;
      r_err      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_y        <= w_y;
      r_otag     <= r_tag;
      r_err      <= w_err;
    end else if (w_xfer) begin
      r_s2_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Completed-operation counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_y     = r_y;
  assign out_tag   = r_otag;
  assign out_err   = r_err;
  assign busy      = r_s1_valid || r_s2_valid;
  assign op_count  = r_count;

endmodule

// File: tb/tb_shift_issue_pipe.sv
module tb_shift_issue_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int EW    = WIDTH + TAG_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [4:0]       in_shamt = '0;
  logic [1:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0]    sb[$];
  logic [CNT_W-1:0] exp_count = '0;

  shift_issue_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_err(out_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference model, written with native operators.
  function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [4:0] s,
                                          input logic [1:0] op, input logic [TAG_W-1:0] tag);
    logic [31:0] y;
    logic [63:0] dbl;
    logic        err;
    err = 1'b0;
    dbl = {a, a} >> s;
    case (op)
      2'b00:   y = a << s;
      2'b01:   y = a >> s;
      2'b10:   y = $unsigned($signed(a) >>> s);
`ifdef SHIFT_ROTATE_EN
      default: y = dbl[31:0];
`else
      default: begin y = 32'h0; err = 1'b1; end
`endif
    endcase
    return {y, tag, err};
  endfunction

  // Scoreboard: push on accept, pop and compare on transfer.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      sb.delete();
      exp_count = '0;
    end else begin
      if (in_valid && in_ready) sb.push_back(model(in_a, in_shamt, in_op, in_tag));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got y=%h tag=%h err=%b, required no result", out_y, out_tag, out_err);
        end else begin
          e = sb.pop_front();
          if ({out_y, out_tag, out_err} !== e) begin
            failures++;
            $display("FAIL sb_result: got y=%h tag=%h err=%b, required y=%h tag=%h err=%b",
                     out_y, out_tag, out_err, e[EW-1 -: WIDTH], e[TAG_W:1], e[0]);
          end
        end
        exp_count = exp_count + 1'b1;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] s,
                       input logic [1:0] op, input logic [TAG_W-1:0] tag);
    in_valid = v; in_a = a; in_shamt = s; in_op = op; in_tag = tag;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; drive(0, 0, 0, 0, 0); out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, op_count, out_y, out_tag, out_err} !== {1'b0, 1'b0, {CNT_W{1'b0}}, 32'h0, {TAG_W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got valid=%b busy=%b cnt=%0d y=%h tag=%h err=%b, required all zero",
               out_valid, busy, op_count, out_y, out_tag, out_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    @(posedge clk); #1 drive(1, 32'h1, 5'd31, 2'b00, 4'd3);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL single_accept: in_ready=%b, required 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early: out_valid=%b at N+1, required 0", out_valid); end
    @(negedge clk);
    checks++;
    if ({out_valid, out_y, out_tag} !== {1'b1, 32'h80000000, 4'd3}) begin
      failures++;
      $display("FAIL single_result: got valid=%b y=%h tag=%h, required 1 80000000 3", out_valid, out_y, out_tag);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, op_count} !== {1'b0, 4'd1}) begin
      failures++;
      $display("FAIL single_count: got valid=%b cnt=%0d, required 0 1", out_valid, op_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ta[3] = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFF0};
    logic [4:0]  ts[3] = '{5'd0, 5'd4, 5'd4};
    logic [1:0]  to[3] = '{2'b01, 2'b10, 2'b10};
    logic [31:0] ty[3] = '{32'hFFFFFFFF, 32'hF8000000, 32'h07FFFFFF};
    out_ready = 1'b1;
    @(posedge clk); #1 drive(1, ta[0], ts[0], to[0], 4'd5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: cycle %0d in_ready=%b, required 1", c, in_ready); end
      end
      if (c >= 2) begin
        checks++;
        if ({out_valid, out_y} !== {1'b1, ty[c-2]}) begin
          failures++;
          $display("FAIL b2b_result: cycle %0d got valid=%b y=%h, required 1 %h", c, out_valid, out_y, ty[c-2]);
        end
      end
      @(posedge clk); #1;
      if (c + 1 < 3) drive(1, ta[c+1], ts[c+1], to[c+1], 4'(c + 6));
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_stall;
    logic [CNT_W-1:0] want;
    bit ok;
    want = exp_count + 4'd3;
    out_ready = 1'b0;
    @(posedge clk); #1 drive(1, 32'h12345678, 5'd8, 2'b01, 4'hA);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_acc0: in_ready=%b, required 1", in_ready); end
    @(posedge clk); #1 drive(1, 32'h0000FFFF, 5'd16, 2'b00, 4'hB);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_acc1: in_ready=%b, required 1", in_ready); end
    @(posedge clk); #1 drive(1, 32'hF0000000, 5'd31, 2'b10, 4'hC);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_y, out_tag} !== {1'b0, 1'b1, 32'h00123456, 4'hA}) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d got ready=%b valid=%b y=%h tag=%h, required 0 1 00123456 a",
                 c, in_ready, out_valid, out_y, out_tag);
      end
      @(posedge clk); #1;
      in_valid = (c != 1);   // one idle cycle: in_ready must not depend on in_valid
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_y} !== {1'b1, 32'h00123456}) begin
      failures++;
      $display("FAIL stall_release: got ready=%b y=%h, required 1 00123456", in_ready, out_y);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_y} !== {1'b1, 32'hFFFF0000}) begin
      failures++; $display("FAIL stall_drain1: got valid=%b y=%h, required 1 ffff0000", out_valid, out_y);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_y} !== {1'b1, 32'hFFFFFFFF}) begin
      failures++; $display("FAIL stall_drain2: got valid=%b y=%h, required 1 ffffffff", out_valid, out_y);
    end
    wait_idle(ok);
    checks++;
    if (!ok || op_count !== want) begin
      failures++; $display("FAIL stall_count: got cnt=%0d idle=%0d, required cnt=%0d idle=1", op_count, ok, want);
    end
  endtask

  task automatic test_reserved;
    bit seen;
    logic [31:0] wy;
    logic        we;
`ifdef SHIFT_ROTATE_EN
    wy = 32'hC0000000; we = 1'b0;
`else
    wy = 32'h0; we = 1'b1;
`endif
    out_ready = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1 drive(1, 32'h80000001, 5'd1, 2'b11, 4'h7);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || {out_y, out_err, out_tag} !== {wy, we, 4'h7}) begin
      failures++;
      $display("FAIL reserved_op: seen=%0d y=%h err=%b tag=%h, required y=%h err=%b tag=7",
               seen, out_y, out_err, out_tag, wy, we);
    end
  endtask

  task automatic test_reset_mid;
    bit stale;
    out_ready = 1'b0;
    @(posedge clk); #1 drive(1, 32'hDEADBEEF, 5'd3, 2'b01, 4'h1);
    @(posedge clk); #1 drive(1, 32'hCAFEF00D, 5'd5, 2'b00, 4'h2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b110) begin
      failures++; $display("FAIL midrst_full: got busy=%b valid=%b ready=%b, required 1 1 0", busy, out_valid, in_ready);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, op_count, in_ready} !== {1'b0, 1'b0, {CNT_W{1'b0}}, 1'b1}) begin
      failures++;
      $display("FAIL midrst_flush: got valid=%b busy=%b cnt=%0d ready=%b, required 0 0 0 1",
               out_valid, busy, op_count, in_ready);
    end
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin failures++; $display("FAIL midrst_stale: got a result after flush, required none"); end
  endtask

  task automatic test_wrap;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1 drive(1, $urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || op_count !== 4'd15) begin
      failures++; $display("FAIL wrap_pre: got cnt=%0d idle=%0d, required cnt=15 idle=1", op_count, ok);
    end
    @(posedge clk); #1 drive(1, 32'h00F0000F, 5'd0, 2'b10, 4'hF);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || op_count !== 4'd0) begin
      failures++; $display("FAIL wrap_zero: got cnt=%0d idle=%0d, required cnt=0 idle=1", op_count, ok);
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [4:0] s;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0: s = 5'd0;
        1: s = 5'd31;
        default: s = 5'($urandom_range(0, 31));
      endcase
      drive(1'($urandom_range(0, 1)), $urandom(), s, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      failures++; $display("FAIL random_drain: idle=%0d pending=%0d, required idle=1 pending=0", ok, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reserved();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
